bram_frame_writer: RTL and testbench

Upstream feeder for the BRAM port-B write path on clk40. Accepts a 32-bit valid/ready word stream delimited by s_last and writes whole frames into a BRAM ring buffer. Publishes a committed write pointer for the PS reader. Supersedes the free-running counter test writer; same BRAM port-B pin set, clocked by clk40.

---
 rtl/bramwr_pkg.sv | 15 +
 rtl/bram_frame_writer.sv | 152 +++++++++++++++
 tb/tb_bram_frame_writer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bramwr_pkg.sv
// Shared types and constants for the BRAM frame writer.
// Optional build macro: BRAMWR_TIMESTAMP_EN.
package bramwr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DROP,
    HDR
  } state_t;

  localparam logic [3:0] BRAM_WE_ALL = 4'hF;
  localparam int         BYTE_SHIFT  = 2;

endpackage

// File: rtl/bram_frame_writer.sv
// Frame-atomic stream writer into a BRAM ring on port B, clk40 domain.
// Define BRAMWR_TIMESTAMP_EN to prefix every frame with a clk40 timestamp word.
module bram_frame_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          DEPTH     = 1024,
  parameter int          ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk40,
  input  logic              rst,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [ADDR_W-1:0] rd_ptr,
  input  logic              clr_overflow,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [31:0]       frame_count,
  output logic              overflow,
  output logic [31:0]       addrb,
  output logic              clkb,
  output logic [31:0]       dinb,
  output logic              enb,
  output logic              rstb,
  output logic [3:0]        web
);

  import bramwr_pkg::*;

  state_t            state, state_n;
  logic [ADDR_W-1:0] wr_idx, wr_idx_n;
  logic [ADDR_W-1:0] frame_start, frame_start_n;
  logic [ADDR_W-1:0] idx_inc;
  logic              full;
  logic              acc;
  logic              wr_go;
  logic              commit;
  logic              ovf_set;
  logic [31:0]       wr_data;

  assign clkb = clk40;
  assign rstb = 1'b0;
  assign web  = enb ? BRAM_WE_ALL : 4'h0;

  // DEPTH is a power of two, so the index wraps by overflow
  assign idx_inc = wr_idx + 1'b1;
  assign full    = (idx_inc == rd_ptr);
  assign acc     = s_valid && s_ready;

`ifdef BRAMWR_TIMESTAMP_EN
  logic [31:0] tstamp;

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) tstamp <= '0;
    else     tstamp <= tstamp + 32'd1;
  end

  // IDLE doubles as the header slot: the stream word waits one cycle
  assign s_ready = !rst && (state != IDLE) && (state != HDR);
`else
  assign s_ready = !rst;
`endif

  always_comb begin
    state_n       = state;
    wr_idx_n      = wr_idx;
    frame_start_n = frame_start;
    wr_go         = 1'b0;
    wr_data       = s_data;
    commit        = 1'b0;
    ovf_set       = 1'b0;
    unique case (state)
      IDLE: begin
`ifdef BRAMWR_TIMESTAMP_EN
        if (s_valid) begin
          if (full) begin
            ovf_set = 1'b1;
            state_n = DROP;
          end else begin
            wr_go         = 1'b1;
            wr_data       = tstamp;
            wr_idx_n      = idx_inc;
            frame_start_n = wr_idx;
            state_n       = STREAM;
          end
        end
`else
        if (acc) begin
          if (full) begin
            ovf_set = 1'b1;
            state_n = s_last ? IDLE : DROP;
          end else begin
            wr_go         = 1'b1;
            wr_idx_n      = idx_inc;
            frame_start_n = wr_idx;
            commit        = s_last;
            state_n       = s_last ? IDLE : STREAM;
          end
        end
`endif
      end
      STREAM: begin
        if (acc) begin
          if (full) begin
            ovf_set  = 1'b1;
            wr_idx_n = frame_start;
            state_n  = s_last ? IDLE : DROP;
          end else begin
            wr_go    = 1'b1;
            wr_idx_n = idx_inc;
            commit   = s_last;
            state_n  = s_last ? IDLE : STREAM;
          end
        end
      end
      DROP: begin
        if (acc && s_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_idx      <= '0;
      frame_start <= '0;
      wr_ptr      <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      addrb       <= BASE_ADDR;
      dinb        <= '0;
      enb         <= 1'b0;
    end else begin
      state       <= state_n;
      wr_idx      <= wr_idx_n;
      frame_start <= frame_start_n;
      enb         <= wr_go;
      if (wr_go) begin
        addrb <= BASE_ADDR + (32'(wr_idx) << BYTE_SHIFT);
        dinb  <= wr_data;
      end
      if (commit) begin
        wr_ptr      <= idx_inc;
        frame_count <= frame_count + 32'd1;
      end
      // a drop on the same edge as a clear keeps the flag set
      if (ovf_set)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_frame_writer.sv
// Randomized + directed bench for bram_frame_writer with a frame-level ring model.
`timescale 1ns/1ps
module tb_bram_frame_writer;

  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk40 = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        s_last = 1'b0;
  logic [2:0]  rd_ptr = '0;
  logic        clr_overflow = 1'b0;
  logic [2:0]  wr_ptr;
  logic [31:0] frame_count;
  logic        overflow;
  logic [31:0] addrb;
  logic        clkb;
  logic [31:0] dinb;
  logic        enb;
  logic        rstb;
  logic [3:0]  web;

  bram_frame_writer #(.BASE_ADDR(BASE), .DEPTH(D)) dut (
    .clk40(clk40), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .rd_ptr(rd_ptr), .clr_overflow(clr_overflow),
    .wr_ptr(wr_ptr), .frame_count(frame_count), .overflow(overflow),
    .addrb(addrb), .clkb(clkb), .dinb(dinb), .enb(enb), .rstb(rstb), .web(web)
  );

  always #5 clk40 = ~clk40;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: committed pointer, length of the open frame, drop flag
  int          m_wp, m_len, m_pos;
  bit          m_drop, m_ovf, m_en;
  logic [31:0] m_fc, m_addr, m_din;

  always @(posedge clk40) begin
    if (rst) begin
      m_wp = 0; m_len = 0; m_drop = 0; m_ovf = 0; m_en = 0;
      m_fc = 0; m_addr = BASE; m_din = 0;
    end else begin
      m_en = 0;
      if (clr_overflow) m_ovf = 0;
      if (s_valid) begin
        if (m_drop) begin
          if (s_last) m_drop = 0;
        end else begin
          m_pos = (m_wp + m_len) % D;
          if ((m_pos + 1) % D == int'(rd_ptr)) begin
            m_ovf  = 1;
            m_len  = 0;
            m_drop = !s_last;
          end else begin
            m_en   = 1;
            m_addr = BASE + 32'(m_pos * 4);
            m_din  = s_data;
            m_len++;
            if (s_last) begin
              m_wp  = (m_pos + 1) % D;
              m_fc  = m_fc + 1;
              m_len = 0;
            end
          end
        end
      end
    end
    #1;
    chk("cyc_enb", {31'b0, enb}, {31'b0, m_en});
    chk("cyc_web", {28'b0, web}, m_en ? 32'hF : 32'h0);
    chk("cyc_addrb", addrb, m_addr);
    chk("cyc_dinb", dinb, m_din);
    chk("cyc_wr_ptr", {29'b0, wr_ptr}, 32'(m_wp));
    chk("cyc_frame_count", frame_count, m_fc);
    chk("cyc_overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("cyc_s_ready", {31'b0, s_ready}, {31'b0, !rst});
    chk("cyc_rstb", {31'b0, rstb}, 32'h0);
  end

  task automatic word(input logic [31:0] d, input logic l, input logic c);
    @(negedge clk40);
    s_valid = 1'b1; s_data = d; s_last = l; clr_overflow = c;
    @(posedge clk40);
    #2;
  endtask

  task automatic setrd(input logic [2:0] v);
    @(negedge clk40);
    s_valid = 1'b0; s_last = 1'b0; clr_overflow = 1'b0; rd_ptr = v;
  endtask

  initial begin
    repeat (2) @(negedge clk40);
    chk("rst_s_ready", {31'b0, s_ready}, 32'h0);
    chk("rst_wr_ptr", {29'b0, wr_ptr}, 32'h0);
    chk("rst_frame_count", frame_count, 32'h0);
    chk("rst_addrb", addrb, BASE);
    chk("rst_web", {28'b0, web}, 32'h0);
    rst = 1'b0;

    // three-word frame from an empty ring
    setrd(3'd0);
    word(32'hA, 1'b0, 1'b0);
    chk("t1_addr0", addrb, 32'h40000000);
    chk("t1_din0", dinb, 32'hA);
    chk("t1_web0", {28'b0, web}, 32'hF);
    word(32'hB, 1'b0, 1'b0);
    chk("t1_addr1", addrb, 32'h40000004);
    chk("t1_din1", dinb, 32'hB);
    word(32'hC, 1'b1, 1'b0);
    chk("t1_addr2", addrb, 32'h40000008);
    chk("t1_wr_ptr", {29'b0, wr_ptr}, 32'd3);
    chk("t1_frame_count", frame_count, 32'd1);
    chk("t1_model_fc", m_fc, 32'd1);

    // nine-word frame cannot fit in an eight-slot ring
    setrd(3'd3);
    for (int i = 0; i < 9; i++) begin
      word(32'h200 + 32'(i), (i == 8), 1'b0);
      if (i == 6) chk("t2_last_write", addrb, 32'h40000004);
      if (i == 6) chk("t2_no_ovf_yet", {31'b0, overflow}, 32'h0);
      if (i == 7) chk("t2_full_enb", {31'b0, enb}, 32'h0);
      if (i == 7) chk("t2_overflow", {31'b0, overflow}, 32'h1);
    end
    chk("t2_wr_ptr", {29'b0, wr_ptr}, 32'd3);
    chk("t2_frame_count", frame_count, 32'd1);

    // move to wr_ptr=6, then a wrapping six-word frame
    setrd(3'd3);
    for (int i = 0; i < 3; i++) word(32'h280 + 32'(i), (i == 2), 1'b0);
    chk("t3_pre_wr_ptr", {29'b0, wr_ptr}, 32'd6);
    setrd(3'd5);
    for (int i = 0; i < 6; i++) begin
      word(32'h300 + 32'(i), (i == 5), 1'b0);
      if (i == 2) chk("t3_wrap_addr", addrb, 32'h40000000);
    end
    chk("t3_last_addr", addrb, 32'h4000000C);
    chk("t3_wr_ptr", {29'b0, wr_ptr}, 32'd4);
    chk("t3_frame_count", frame_count, 32'd3);
    chk("t3_model_wp", 32'(m_wp), 32'd4);

    // ring is full (wr 4, rd 5): drop with simultaneous clear
    setrd(3'd5);
    word(32'h500, 1'b0, 1'b1);
    chk("t5_set_wins", {31'b0, overflow}, 32'h1);
    chk("t5_drop_enb", {31'b0, enb}, 32'h0);
    word(32'h501, 1'b1, 1'b0);
    @(negedge clk40);
    s_valid = 1'b0; s_last = 1'b0; clr_overflow = 1'b1;
    @(posedge clk40);
    #2;
    chk("t5_cleared", {31'b0, overflow}, 32'h0);

    // reset mid-frame
    setrd(3'd0);
    word(32'h400, 1'b0, 1'b0);
    @(negedge clk40);
    s_valid = 1'b1; s_data = 32'h401; s_last = 1'b0; rst = 1'b1;
    @(posedge clk40);
    #2;
    chk("t4_enb", {31'b0, enb}, 32'h0);
    chk("t4_wr_ptr", {29'b0, wr_ptr}, 32'h0);
    chk("t4_frame_count", frame_count, 32'h0);
    @(negedge clk40);
    rst = 1'b0; s_valid = 1'b0;
    word(32'h410, 1'b1, 1'b0);
    chk("t4_restart_addr", addrb, 32'h40000000);
    chk("t4_restart_wr_ptr", {29'b0, wr_ptr}, 32'd1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk40);
      rst          = ($urandom_range(0, 299) == 0);
      s_valid      = ($urandom_range(0, 3) != 0);
      s_data       = $urandom;
      s_last       = ($urandom_range(0, 4) == 0);
      clr_overflow = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        rd_ptr = $urandom_range(0, 1) ? 3'(m_wp) : 3'($urandom);
    end
    @(negedge clk40);
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(negedge clk40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
